// File: rtl/ac_codec_slave_if.sv
// Serial audio link between an acDriver-style master and the codec-side slave.
interface ac_codec_slave_if;
  logic audBclk;
  logic audAdcLrck;
  logic audAdcData;
  logic audDacLrck;
  logic audDacData;

  modport master (
    output audBclk, audAdcLrck, audDacLrck, audDacData,
    input  audAdcData
  );

  modport slave (
    input  audBclk, audAdcLrck, audDacLrck, audDacData,
    output audAdcData
  );
endinterface

// File: rtl/ac_codec_slave.sv
// Codec-side slave of the acDriver serial audio link: oversamples the master's
// bit/channel clocks, receives DAC words and transmits ADC words.
module ac_codec_slave #(
  parameter string       INTERFACE_TYPE = "LEFT-JUSTIFIED",
  parameter int unsigned DATA_WDT       = 32,
  parameter int unsigned SLOT_LEN       = 32,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                clk,
  input  logic                reset,
  ac_codec_slave_if.slave     link,
  input  logic [DATA_WDT-1:0] txDataL,
  input  logic [DATA_WDT-1:0] txDataR,
  output logic                txReq,
  output logic [DATA_WDT-1:0] rxDataL,
  output logic [DATA_WDT-1:0] rxDataR,
  output logic                rxValid,
  output logic                frameErr
);

  localparam bit          IS_I2S   = (INTERFACE_TYPE == "I2S");
  localparam bit          IS_RJ    = (INTERFACE_TYPE == "RIGHT-JUSTIFIED");
  localparam int unsigned CNT_W    = $clog2(SLOT_LEN + 1);
  localparam int unsigned WIN_LO   = IS_RJ ? (SLOT_LEN - DATA_WDT) : (IS_I2S ? 32'd1 : 32'd0);
  localparam logic [CNT_W-1:0] WIN_LO_C = CNT_W'(WIN_LO);
  localparam logic [CNT_W-1:0] WDT_C    = CNT_W'(DATA_WDT);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_LEN);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(SLOT_LEN - 1);
  localparam logic             LEFT_LVL = IS_I2S ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    RX_WAIT,
    RX_LEFT,
    RX_RIGHT
  } rxState_t;

  // Counter values below WIN_LO wrap to large offsets, so one compare covers both ends.
  function automatic logic inWindow(input logic [CNT_W-1:0] n);
    inWindow = (n - WIN_LO_C) < WDT_C;
  endfunction

  logic [SYNC_STAGES-1:0] bclkSync;
  logic [SYNC_STAGES-1:0] adcLrckSync;
  logic [SYNC_STAGES-1:0] dacLrckSync;
  logic [SYNC_STAGES-1:0] dacDataSync;
  logic                   bclkPrev;
  logic                   bclkS;
  logic                   adcLrckS;
  logic                   dacLrckS;
  logic                   dacDataS;
  logic                   riseStb;
  logic                   fallStb;

  // Input synchronizers and bit-clock edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclkSync    <= '0;
      adcLrckSync <= '0;
      dacLrckSync <= '0;
      dacDataSync <= '0;
      bclkPrev    <= 1'b0;
    end else begin
      bclkSync    <= {bclkSync[SYNC_STAGES-2:0], link.audBclk};
      adcLrckSync <= {adcLrckSync[SYNC_STAGES-2:0], link.audAdcLrck};
      dacLrckSync <= {dacLrckSync[SYNC_STAGES-2:0], link.audDacLrck};
      dacDataSync <= {dacDataSync[SYNC_STAGES-2:0], link.audDacData};
      bclkPrev    <= bclkSync[SYNC_STAGES-1];
    end
  end

  assign bclkS    = bclkSync[SYNC_STAGES-1];
  assign adcLrckS = adcLrckSync[SYNC_STAGES-1];
  assign dacLrckS = dacLrckSync[SYNC_STAGES-1];
  assign dacDataS = dacDataSync[SYNC_STAGES-1];
  assign riseStb  = bclkS & ~bclkPrev;
  assign fallStb  = ~bclkS & bclkPrev;

  // ADC-side slot tracker; the first fallStb only learns the lrck level
  logic             adcKnown;
  logic             adcSynced;
  logic             adcLrckReg;
  logic [CNT_W-1:0] adcCnt;
  logic [CNT_W-1:0] adcCntNext;
  logic             adcEdge;
  logic             adcLeftEdge;
  logic             adcErr;

  always_comb begin
    adcEdge     = fallStb & adcKnown & (adcLrckS != adcLrckReg);
    adcLeftEdge = adcEdge & (adcLrckS == LEFT_LVL);
    adcErr      = adcEdge & adcSynced & (adcCnt != LAST_C);
    adcCntNext  = adcCnt;
    if (adcEdge)
      adcCntNext = '0;
    else if (adcCnt != SLOT_C)
      adcCntNext = adcCnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adcKnown   <= 1'b0;
      adcSynced  <= 1'b0;
      adcLrckReg <= 1'b0;
      adcCnt     <= '0;
    end else if (fallStb) begin
      adcKnown   <= 1'b1;
      adcLrckReg <= adcLrckS;
      adcCnt     <= adcCntNext;
      if (adcEdge)
        adcSynced <= 1'b1;
    end
  end

  // DAC-side slot tracker
  logic             dacKnown;
  logic             dacSynced;
  logic             dacLrckReg;
  logic [CNT_W-1:0] dacCnt;
  logic [CNT_W-1:0] dacCntNext;
  logic             dacEdge;
  logic             dacLeftEdge;
  logic             dacErr;

  always_comb begin
    dacEdge     = fallStb & dacKnown & (dacLrckS != dacLrckReg);
    dacLeftEdge = dacEdge & (dacLrckS == LEFT_LVL);
    dacErr      = dacEdge & dacSynced & (dacCnt != LAST_C);
    dacCntNext  = dacCnt;
    if (dacEdge)
      dacCntNext = '0;
    else if (dacCnt != SLOT_C)
      dacCntNext = dacCnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dacKnown   <= 1'b0;
      dacSynced  <= 1'b0;
      dacLrckReg <= 1'b0;
      dacCnt     <= '0;
    end else if (fallStb) begin
      dacKnown   <= 1'b1;
      dacLrckReg <= dacLrckS;
      dacCnt     <= dacCntNext;
      if (dacEdge)
        dacSynced <= 1'b1;
    end
  end

  // ADC transmit: the shift register is reloaded at each slot boundary
  logic [DATA_WDT-1:0] txSh;
  logic [DATA_WDT-1:0] txHoldR;
  logic [DATA_WDT-1:0] txWord;
  logic                adcDataQ;
  logic                adcDrive;

  always_comb begin
    txWord = txSh;
    if (adcEdge)
      txWord = adcLeftEdge ? txDataL : txHoldR;
    adcDrive = (adcSynced | adcEdge) & inWindow(adcCntNext);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txSh     <= '0;
      txHoldR  <= '0;
      adcDataQ <= 1'b0;
      txReq    <= 1'b0;
    end else begin
      txReq <= adcLeftEdge;
      if (adcLeftEdge)
        txHoldR <= txDataR;
      if (fallStb) begin
        if (adcDrive) begin
          adcDataQ <= txWord[DATA_WDT-1];
          txSh     <= txWord << 1;
        end else begin
          adcDataQ <= 1'b0;
          txSh     <= txWord;
        end
      end
    end
  end

  assign link.audAdcData = adcDataQ;

  // DAC receive shift registers, sampled on the master's rising edge
  logic [DATA_WDT-1:0] rxShL;
  logic [DATA_WDT-1:0] rxShR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxShL <= '0;
      rxShR <= '0;
    end else if (riseStb && dacSynced && inWindow(dacCnt)) begin
      if (dacLrckReg == LEFT_LVL)
        rxShL <= {rxShL[DATA_WDT-2:0], dacDataS};
      else
        rxShR <= {rxShR[DATA_WDT-2:0], dacDataS};
    end
  end

  // Frame tracker: a word pair is published only after a clean left+right frame
  rxState_t rxState;
  rxState_t rxStateNext;
  logic     rxLoad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rxState <= RX_WAIT;
    else
      rxState <= rxStateNext;
  end

  always_comb begin
    rxStateNext = rxState;
    rxLoad      = 1'b0;
    if (dacEdge) begin
      if (dacLeftEdge) begin
        rxLoad      = (rxState == RX_RIGHT) && !dacErr;
        rxStateNext = RX_LEFT;
      end else begin
        rxStateNext = ((rxState == RX_LEFT) && !dacErr) ? RX_RIGHT : RX_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxDataL  <= '0;
      rxDataR  <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      rxValid  <= rxLoad;
      frameErr <= adcErr | dacErr;
      if (rxLoad) begin
        rxDataL <= rxShL;
        rxDataR <= rxShR;
      end
    end
  end

endmodule

// File: tb/tb_ac_codec_slave.sv
// Directed bench for ac_codec_slave: one master waveform drives LJ, I2S and RJ instances.
module tb_ac_codec_slave;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic mBclk = 1'b1;
  logic mLrck = 1'b0;
  logic mDac  = 1'b0;
  int   sel   = 0;

  ac_codec_slave_if ljIf();
  ac_codec_slave_if i2sIf();
  ac_codec_slave_if rjIf();

  assign ljIf.audBclk     = mBclk;
  assign ljIf.audAdcLrck  = mLrck;
  assign ljIf.audDacLrck  = mLrck;
  assign ljIf.audDacData  = mDac;
  assign i2sIf.audBclk    = mBclk;
  assign i2sIf.audAdcLrck = mLrck;
  assign i2sIf.audDacLrck = mLrck;
  assign i2sIf.audDacData = mDac;
  assign rjIf.audBclk     = mBclk;
  assign rjIf.audAdcLrck  = mLrck;
  assign rjIf.audDacLrck  = mLrck;
  assign rjIf.audDacData  = mDac;

  logic [31:0] ljTxL = '0, ljTxR = '0;
  logic [31:0] ljRxL, ljRxR;
  logic        ljTxReq, ljRxValid, ljErr;
  logic [23:0] i2sTxL = '0, i2sTxR = '0;
  logic [23:0] i2sRxL, i2sRxR;
  logic        i2sTxReq, i2sRxValid, i2sErr;
  logic [15:0] rjTxL = '0, rjTxR = '0;
  logic [15:0] rjRxL, rjRxR;
  logic        rjTxReq, rjRxValid, rjErr;

  ac_codec_slave #(.INTERFACE_TYPE("LEFT-JUSTIFIED"), .DATA_WDT(32), .SLOT_LEN(32), .SYNC_STAGES(2)) uLj (
    .clk(clk), .reset(reset), .link(ljIf.slave),
    .txDataL(ljTxL), .txDataR(ljTxR), .txReq(ljTxReq),
    .rxDataL(ljRxL), .rxDataR(ljRxR), .rxValid(ljRxValid), .frameErr(ljErr));

  ac_codec_slave #(.INTERFACE_TYPE("I2S"), .DATA_WDT(24), .SLOT_LEN(32), .SYNC_STAGES(2)) uI2s (
    .clk(clk), .reset(reset), .link(i2sIf.slave),
    .txDataL(i2sTxL), .txDataR(i2sTxR), .txReq(i2sTxReq),
    .rxDataL(i2sRxL), .rxDataR(i2sRxR), .rxValid(i2sRxValid), .frameErr(i2sErr));

  ac_codec_slave #(.INTERFACE_TYPE("RIGHT-JUSTIFIED"), .DATA_WDT(16), .SLOT_LEN(32), .SYNC_STAGES(2)) uRj (
    .clk(clk), .reset(reset), .link(rjIf.slave),
    .txDataL(rjTxL), .txDataR(rjTxR), .txReq(rjTxReq),
    .rxDataL(rjRxL), .rxDataR(rjRxR), .rxValid(rjRxValid), .frameErr(rjErr));

  logic selAdc, selRxValid, selTxReq, selErr;
  always_comb begin
    case (sel)
      1:       begin selAdc = i2sIf.audAdcData; selRxValid = i2sRxValid; selTxReq = i2sTxReq; selErr = i2sErr; end
      2:       begin selAdc = rjIf.audAdcData;  selRxValid = rjRxValid;  selTxReq = rjTxReq;  selErr = rjErr;  end
      default: begin selAdc = ljIf.audAdcData;  selRxValid = ljRxValid;  selTxReq = ljTxReq;  selErr = ljErr;  end
    endcase
  end

  // Pulse counters for the selected instance
  int rvCnt = 0, tqCnt = 0, erCnt = 0;
  always @(negedge clk) begin
    if (selRxValid) rvCnt <= rvCnt + 1;
    if (selTxReq)   tqCnt <= tqCnt + 1;
    if (selErr)     erCnt <= erCnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // One slot of len bclks: data/lrck change on the fall, ADC sampled just before the rise
  task automatic drive_slot(input int len, input logic lvl, input logic [31:0] dacPat,
                            output logic [31:0] adcPat);
    logic [4:0] idx;
    adcPat = '0;
    for (int i = 0; i < len; i++) begin
      idx   = 5'(31 - i);
      mBclk = 1'b0;
      mLrck = lvl;
      mDac  = dacPat[idx];
      repeat (HALF) @(negedge clk);
      adcPat[idx] = selAdc;
      mBclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic apply_reset(input logic rightLvl);
    @(negedge clk);
    reset = 1'b0;
    mBclk = 1'b1;
    mLrck = rightLvl;
    mDac  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ljRxL, ljRxR, ljRxValid, ljTxReq, ljErr, ljIf.audAdcData} !== '0) begin
      errors++; $display("FAIL reset_lj: got %h %h %b%b%b%b want all zero", ljRxL, ljRxR, ljRxValid, ljTxReq, ljErr, ljIf.audAdcData);
    end
    checks++;
    if ({i2sRxL, i2sRxR, i2sRxValid, i2sTxReq, i2sErr, i2sIf.audAdcData} !== '0) begin
      errors++; $display("FAIL reset_i2s: got %h %h %b%b%b%b want all zero", i2sRxL, i2sRxR, i2sRxValid, i2sTxReq, i2sErr, i2sIf.audAdcData);
    end
    checks++;
    if ({rjRxL, rjRxR, rjRxValid, rjTxReq, rjErr, rjIf.audAdcData} !== '0) begin
      errors++; $display("FAIL reset_rj: got %h %h %b%b%b%b want all zero", rjRxL, rjRxR, rjRxValid, rjTxReq, rjErr, rjIf.audAdcData);
    end
  endtask

  task automatic test_left_justified();
    logic [31:0] aL, aR;
    int rv0, tq0, er0;
    sel = 0;
    apply_reset(1'b0);
    ljTxL = 32'hDEAD_BEEF; ljTxR = 32'h0BAD_F00D;
    rv0 = rvCnt; tq0 = tqCnt; er0 = erCnt;
    drive_slot(32, 1'b0, 32'hFFFF_FFFF, aR);
    checks++;
    if (aR !== 32'h0 || tqCnt - tq0 !== 0) begin
      errors++; $display("FAIL lj_presync: adc %h txReq %0d want 0 0", aR, tqCnt - tq0);
    end
    drive_slot(32, 1'b1, 32'hA5A5_0F0F, aL);
    checks++;
    if (aL !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lj_adc_left: got %h want DEADBEEF", aL); end
    checks++;
    if (tqCnt - tq0 !== 1 || rvCnt - rv0 !== 0) begin
      errors++; $display("FAIL lj_first_left: txReq %0d rxValid %0d want 1 0", tqCnt - tq0, rvCnt - rv0);
    end
    ljTxR = 32'hFFFF_0000;
    drive_slot(32, 1'b0, 32'h1234_5678, aR);
    checks++;
    if (aR !== 32'h0BAD_F00D) begin errors++; $display("FAIL lj_adc_right_latched: got %h want 0BADF00D", aR); end
    drive_slot(32, 1'b1, 32'hA5A5_0F0F, aL);
    checks++;
    if (rvCnt - rv0 !== 1) begin errors++; $display("FAIL lj_rxvalid_count: got %0d want 1", rvCnt - rv0); end
    checks++;
    if (ljRxL !== 32'hA5A5_0F0F || ljRxR !== 32'h1234_5678) begin
      errors++; $display("FAIL lj_rx_data: got %h %h want A5A50F0F 12345678", ljRxL, ljRxR);
    end
    drive_slot(32, 1'b0, 32'h1234_5678, aR);
    checks++;
    if (aR !== 32'hFFFF_0000 || tqCnt - tq0 !== 2 || erCnt - er0 !== 0) begin
      errors++; $display("FAIL lj_second_frame: adcR %h txReq %0d err %0d want FFFF0000 2 0", aR, tqCnt - tq0, erCnt - er0);
    end
  endtask

  task automatic test_i2s();
    logic [31:0] aL, aR;
    int rv0;
    sel = 1;
    apply_reset(1'b1);
    i2sTxL = 24'h80_0001; i2sTxR = 24'h7F_FFFE;
    rv0 = rvCnt;
    drive_slot(32, 1'b1, 32'h0, aR);
    drive_slot(32, 1'b0, {1'b1, 24'h80_0001, 7'h55}, aL);
    checks++;
    if (aL !== {1'b0, 24'h80_0001, 7'h00}) begin errors++; $display("FAIL i2s_adc_left: got %h want 40000080", aL); end
    drive_slot(32, 1'b1, {1'b0, 24'h7F_FFFE, 7'h7F}, aR);
    checks++;
    if (aR !== {1'b0, 24'h7F_FFFE, 7'h00}) begin errors++; $display("FAIL i2s_adc_right: got %h want 3FFFFF00", aR); end
    drive_slot(32, 1'b0, 32'h0, aL);
    checks++;
    if (rvCnt - rv0 !== 1 || i2sRxL !== 24'h80_0001 || i2sRxR !== 24'h7F_FFFE) begin
      errors++; $display("FAIL i2s_rx: valid %0d data %h %h want 1 800001 7FFFFE", rvCnt - rv0, i2sRxL, i2sRxR);
    end
  endtask

  task automatic test_right_justified();
    logic [31:0] aL, aR;
    int rv0;
    sel = 2;
    apply_reset(1'b0);
    rjTxL = 16'hC3A5; rjTxR = 16'h0F0F;
    rv0 = rvCnt;
    drive_slot(32, 1'b0, 32'h0, aR);
    drive_slot(32, 1'b1, {16'hFFFF, 16'hC3A5}, aL);
    checks++;
    if (aL !== 32'h0000_C3A5) begin errors++; $display("FAIL rj_adc_left: got %h want 0000C3A5", aL); end
    drive_slot(32, 1'b0, {16'h1234, 16'h5A3C}, aR);
    checks++;
    if (aR !== 32'h0000_0F0F) begin errors++; $display("FAIL rj_adc_right: got %h want 00000F0F", aR); end
    drive_slot(32, 1'b1, 32'h0, aL);
    checks++;
    if (rvCnt - rv0 !== 1 || rjRxL !== 16'hC3A5 || rjRxR !== 16'h5A3C) begin
      errors++; $display("FAIL rj_rx: valid %0d data %h %h want 1 C3A5 5A3C", rvCnt - rv0, rjRxL, rjRxR);
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] aL, aR;
    int rv0, er0;
    sel = 0;
    apply_reset(1'b0);
    ljTxL = 32'h1357_9BDF; ljTxR = 32'h2468_ACE0;
    rv0 = rvCnt; er0 = erCnt;
    drive_slot(32, 1'b0, 32'h0, aR);
    drive_slot(32, 1'b1, 32'h0F0F_F0F0, aL);
    drive_slot(32, 1'b0, 32'h3333_CCCC, aR);
    drive_slot(31, 1'b1, 32'h1111_1111, aL);
    checks++;
    if (rvCnt - rv0 !== 1 || erCnt - er0 !== 0) begin
      errors++; $display("FAIL err_before: valid %0d err %0d want 1 0", rvCnt - rv0, erCnt - er0);
    end
    drive_slot(32, 1'b0, 32'h2222_2222, aR);
    checks++;
    if (erCnt - er0 !== 1) begin errors++; $display("FAIL err_pulse: got %0d want 1", erCnt - er0); end
    drive_slot(32, 1'b1, 32'hCAFE_F00D, aL);
    checks++;
    if (rvCnt - rv0 !== 1) begin errors++; $display("FAIL err_discard: valid %0d want 1", rvCnt - rv0); end
    checks++;
    if (aL !== 32'h1357_9BDF) begin errors++; $display("FAIL err_adc_continues: got %h want 13579BDF", aL); end
    drive_slot(32, 1'b0, 32'h0000_FFFF, aR);
    drive_slot(32, 1'b1, 32'h0, aL);
    checks++;
    if (rvCnt - rv0 !== 2 || ljRxL !== 32'hCAFE_F00D || ljRxR !== 32'h0000_FFFF || erCnt - er0 !== 1) begin
      errors++; $display("FAIL err_recover: valid %0d data %h %h err %0d want 2 CAFEF00D 0000FFFF 1",
                         rvCnt - rv0, ljRxL, ljRxR, erCnt - er0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] aL, aR;
    int rv0, tq0, er0;
    sel = 0;
    drive_slot(32, 1'b0, 32'h0, aR);
    drive_slot(10, 1'b1, 32'hFFFF_FFFF, aL);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ljRxL, ljRxR, ljRxValid, ljTxReq, ljErr, ljIf.audAdcData} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h %h %b%b%b%b want all zero", ljRxL, ljRxR, ljRxValid, ljTxReq, ljErr, ljIf.audAdcData);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rv0 = rvCnt; tq0 = tqCnt; er0 = erCnt;
    drive_slot(22, 1'b1, 32'hFFFF_FFFF, aL);
    drive_slot(32, 1'b0, 32'hFFFF_FFFF, aR);
    checks++;
    if (aL !== 32'h0 || tqCnt - tq0 !== 0) begin
      errors++; $display("FAIL mid_unsynced: adc %h txReq %0d want 0 0", aL, tqCnt - tq0);
    end
    drive_slot(32, 1'b1, 32'h0F0F_0F0F, aL);
    checks++;
    if (rvCnt - rv0 !== 0 || tqCnt - tq0 !== 1) begin
      errors++; $display("FAIL mid_first_frame: valid %0d txReq %0d want 0 1", rvCnt - rv0, tqCnt - tq0);
    end
    drive_slot(32, 1'b0, 32'hF0F0_F0F0, aR);
    drive_slot(32, 1'b1, 32'h0, aL);
    checks++;
    if (rvCnt - rv0 !== 1 || ljRxL !== 32'h0F0F_0F0F || ljRxR !== 32'hF0F0_F0F0 || erCnt - er0 !== 0) begin
      errors++; $display("FAIL mid_recover: valid %0d data %h %h err %0d want 1 0F0F0F0F F0F0F0F0 0",
                         rvCnt - rv0, ljRxL, ljRxR, erCnt - er0);
    end
  endtask

  initial begin
    test_reset();
    test_left_justified();
    test_i2s();
    test_right_justified();
    test_frame_err();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
